// File: rtl/fetch_req_ctrl_if.sv
// fetch_req_ctrl_if: request/response bus between the fetch unit and the instruction memory
// Signals: mem_req_valid/mem_req_ready/mem_addr carry the request;
// mem_rsp_valid/mem_rsp_data carry the response.
// The master modport is the fetch side and the slave modport is the memory side.
interface fetch_req_ctrl_if #(
  parameter int XLEN = 64,
  parameter int ILEN = 32
);
  logic            mem_req_valid;
  logic            mem_req_ready;
  logic [XLEN-1:0] mem_addr;
  logic            mem_rsp_valid;
  logic [ILEN-1:0] mem_rsp_data;
  modport master (output mem_req_valid, mem_addr, input mem_req_ready, mem_rsp_valid, mem_rsp_data);
  modport slave (input mem_req_valid, mem_addr, output mem_req_ready, mem_rsp_valid, mem_rsp_data);
endinterface

// File: rtl/fetch_req_ctrl.sv
// fetch_req_ctrl: one-at-a-time instruction fetch from a variable-latency memory into IF/ID
// Ports: clock / reset_n (async, active-low); pc_addr in and pc_stall out for the PC register.
// flush (redirect) and id_stall come from the pipeline; mem is the memory bus (master side).
// instr_valid, instr, instr_pc and fetch_fault feed the IF/ID register.
// Optional: define FETCH_MISALIGN_EN to turn misaligned PCs into a faulting bubble
// instead of a memory request.
module fetch_req_ctrl #(
  parameter int XLEN = 64,
  parameter int ILEN = 32,
  parameter logic [ILEN-1:0] BUBBLE_INSTR = 32'h00000013
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [XLEN-1:0]     pc_addr,
  input  logic                flush,
  input  logic                id_stall,
  output logic                pc_stall,
  fetch_req_ctrl_if.master    mem,
  output logic                instr_valid,
  output logic [ILEN-1:0]     instr,
  output logic [XLEN-1:0]     instr_pc,
  output logic                fetch_fault
);
  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, DRAIN} state_t;
  state_t state, state_nxt;
  logic [ILEN-1:0] skid_data, dlv_data;
  logic [XLEN-1:0] skid_pc, dlv_pc;
  logic slot_free, misalign, deliver, issue, capture;
  assign slot_free = !instr_valid || !id_stall;
`ifdef FETCH_MISALIGN_EN
  assign misalign = state == IDLE && pc_addr[1:0] != 2'b00;
`else
  assign misalign = 1'b0;
`endif
  assign pc_stall = !(flush || deliver);
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nxt;
  // A misaligned PC never leaves IDLE: it either delivers its bubble or waits for a free slot.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = (flush || misalign) ? IDLE : REQ;
      REQ:     state_nxt = mem.mem_req_ready ? (flush ? DRAIN : WAIT) : (flush ? IDLE : REQ);
      WAIT:    state_nxt = flush ? (mem.mem_rsp_valid ? IDLE : DRAIN) :
                           !mem.mem_rsp_valid ? WAIT : slot_free ? IDLE : HOLD;
      HOLD:    state_nxt = (flush || slot_free) ? IDLE : HOLD;
      DRAIN:   state_nxt = mem.mem_rsp_valid ? IDLE : DRAIN;
      default: state_nxt = IDLE;
    endcase
  end
  always_comb begin
    issue    = state == IDLE && !flush && !misalign;
    capture  = state == WAIT && !flush && mem.mem_rsp_valid && !slot_free;
    deliver  = !flush && slot_free && (misalign || state == HOLD || (state == WAIT && mem.mem_rsp_valid));
    dlv_data = state == HOLD ? skid_data : misalign ? BUBBLE_INSTR : mem.mem_rsp_data;
    dlv_pc   = state == HOLD ? skid_pc : misalign ? pc_addr : mem.mem_addr;
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      mem.mem_req_valid <= 1'b0;
      mem.mem_addr      <= '0;
      skid_data         <= '0;
      skid_pc           <= '0;
      instr_valid       <= 1'b0;
      instr             <= BUBBLE_INSTR;
      instr_pc          <= '0;
      fetch_fault       <= 1'b0;
    end else begin
      if (issue) begin
        mem.mem_req_valid <= 1'b1;
        mem.mem_addr      <= pc_addr;
      end else if (state == REQ && (mem.mem_req_ready || flush)) mem.mem_req_valid <= 1'b0;
      if (capture) begin
        skid_data <= mem.mem_rsp_data;
        skid_pc   <= mem.mem_addr;
      end
      if (flush) begin
        instr_valid <= 1'b0;
        instr       <= BUBBLE_INSTR;
        fetch_fault <= 1'b0;
      end else if (deliver) begin
        instr_valid <= 1'b1;
        instr       <= dlv_data;
        instr_pc    <= dlv_pc;
        fetch_fault <= misalign;
      end else if (!id_stall) begin
        instr_valid <= 1'b0;
        instr       <= BUBBLE_INSTR;
      end
    end
endmodule

// File: tb/tb_fetch_req_ctrl.sv
// tb_fetch_req_ctrl: directed per-cycle vector bench for fetch_req_ctrl
module tb_fetch_req_ctrl;
  localparam logic [31:0] B = 32'h00000013;
  logic clock = 1'b0;
  always #5 clock = ~clock;
  logic reset_n, flush, id_stall, pc_stall, instr_valid, fetch_fault;
  logic [63:0] pc_addr, instr_pc;
  logic [31:0] instr;
  fetch_req_ctrl_if #(.XLEN(64), .ILEN(32)) bus ();
  fetch_req_ctrl #(.XLEN(64), .ILEN(32)) dut (
    .clock(clock), .reset_n(reset_n), .pc_addr(pc_addr), .flush(flush), .id_stall(id_stall),
    .pc_stall(pc_stall), .mem(bus), .instr_valid(instr_valid), .instr(instr),
    .instr_pc(instr_pc), .fetch_fault(fetch_fault)
  );
  typedef struct {
    logic [63:0] pc;
    logic        fl, ids, rdy, rv;
    logic [31:0] rd;
    logic        e_stall, e_rv;
    logic [63:0] e_addr;
    logic        e_iv;
    logic [31:0] e_instr;
    logic [63:0] e_ipc;
  } vec_t;
  vec_t tbl[$];
  int n_chk = 0, n_fail = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic add(input logic [63:0] pc, input logic fl, ids, rdy, rv, input logic [31:0] rd,
                     input logic e_stall, e_rv, input logic [63:0] e_addr, input logic e_iv,
                     input logic [31:0] e_instr, input logic [63:0] e_ipc);
    tbl.push_back('{pc, fl, ids, rdy, rv, rd, e_stall, e_rv, e_addr, e_iv, e_instr, e_ipc});
  endtask
  task automatic drive(input logic [63:0] pc, input logic fl, ids, rdy, rv, input logic [31:0] rd);
    pc_addr = pc; flush = fl; id_stall = ids;
    bus.mem_req_ready = rdy; bus.mem_rsp_valid = rv; bus.mem_rsp_data = rd;
  endtask
  task automatic chk_regs(input string t, input logic rv, input logic [63:0] addr, input logic iv,
                          input logic [31:0] ins, input logic [63:0] ipc, input logic ff);
    chk({t, " mem_req_valid"}, 64'(bus.mem_req_valid), 64'(rv));
    chk({t, " mem_addr"}, bus.mem_addr, addr);
    chk({t, " instr_valid"}, 64'(instr_valid), 64'(iv));
    chk({t, " instr"}, 64'(instr), 64'(ins));
    chk({t, " instr_pc"}, instr_pc, ipc);
    chk({t, " fetch_fault"}, 64'(fetch_fault), 64'(ff));
  endtask
  initial begin
    //   pc     fl ids rdy rv data           stall rv addr   iv instr          ipc
    add('h0,   0, 0, 1, 0, 0,             1, 0, 'h0,   0, B,             'h0);
    add('h0,   0, 0, 1, 0, 0,             1, 1, 'h0,   0, B,             'h0);
    add('h0,   0, 0, 1, 1, 32'h00500093,  0, 0, 'h0,   0, B,             'h0);
    add('h40,  0, 0, 0, 0, 0,             1, 0, 'h0,   1, 32'h00500093,  'h0);
    add('h40,  0, 0, 0, 0, 0,             1, 1, 'h40,  0, B,             'h0);
    add('h40,  0, 0, 0, 0, 0,             1, 1, 'h40,  0, B,             'h0);
    add('h40,  0, 0, 0, 0, 0,             1, 1, 'h40,  0, B,             'h0);
    add('h40,  0, 0, 1, 0, 0,             1, 1, 'h40,  0, B,             'h0);
    add('h40,  0, 0, 0, 0, 0,             1, 0, 'h40,  0, B,             'h0);
    add('h40,  0, 0, 0, 1, 32'h00000517,  0, 0, 'h40,  0, B,             'h0);
    add('h44,  0, 1, 0, 0, 0,             1, 0, 'h40,  1, 32'h00000517,  'h40);
    add('h44,  0, 1, 1, 0, 0,             1, 1, 'h44,  1, 32'h00000517,  'h40);
    add('h44,  0, 1, 0, 1, 32'h00A00113,  1, 0, 'h44,  1, 32'h00000517,  'h40);
    add('h44,  0, 1, 0, 0, 0,             1, 0, 'h44,  1, 32'h00000517,  'h40);
    add('h44,  0, 0, 0, 0, 0,             0, 0, 'h44,  1, 32'h00000517,  'h40);
    add('h48,  0, 0, 0, 0, 0,             1, 0, 'h44,  1, 32'h00A00113,  'h44);
    add('h48,  0, 0, 1, 0, 0,             1, 1, 'h48,  0, B,             'h44);
    add('h48,  1, 0, 0, 0, 0,             0, 0, 'h48,  0, B,             'h44);
    add('h100, 0, 0, 0, 0, 0,             1, 0, 'h48,  0, B,             'h44);
    add('h100, 0, 0, 0, 1, 32'hDEADBEEF,  1, 0, 'h48,  0, B,             'h44);
    add('h100, 0, 0, 0, 0, 0,             1, 0, 'h48,  0, B,             'h44);
    add('h100, 0, 0, 1, 0, 0,             1, 1, 'h100, 0, B,             'h44);
    add('h100, 0, 0, 0, 1, 32'h00700193,  0, 0, 'h100, 0, B,             'h44);
    add('h104, 0, 0, 0, 0, 0,             1, 0, 'h100, 1, 32'h00700193,  'h100);
    add('h104, 1, 0, 0, 0, 0,             0, 1, 'h104, 0, B,             'h100);
    add('h200, 0, 0, 0, 0, 0,             1, 0, 'h104, 0, B,             'h100);
    add('h200, 1, 0, 1, 0, 0,             0, 1, 'h200, 0, B,             'h100);
    add('h200, 0, 0, 0, 1, 32'h11111111,  1, 0, 'h200, 0, B,             'h100);
    add('h300, 0, 0, 0, 0, 0,             1, 0, 'h200, 0, B,             'h100);
    add('h300, 0, 0, 1, 0, 0,             1, 1, 'h300, 0, B,             'h100);
    add('h300, 1, 0, 0, 1, 32'h22222222,  0, 0, 'h300, 0, B,             'h100);
    add('h400, 0, 0, 0, 1, 32'h33333333,  1, 0, 'h300, 0, B,             'h100);
    add('h400, 0, 0, 0, 1, 32'h44444444,  1, 1, 'h400, 0, B,             'h100);
    reset_n = 1'b0;
    drive('h0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clock);
    chk_regs("reset", 0, 'h0, 0, B, 'h0, 0);
    reset_n = 1'b1;
    foreach (tbl[i]) begin
      drive(tbl[i].pc, tbl[i].fl, tbl[i].ids, tbl[i].rdy, tbl[i].rv, tbl[i].rd);
      #1;
      chk($sformatf("v%0d pc_stall", i), 64'(pc_stall), 64'(tbl[i].e_stall));
      chk_regs($sformatf("v%0d", i), tbl[i].e_rv, tbl[i].e_addr, tbl[i].e_iv, tbl[i].e_instr, tbl[i].e_ipc, 0);
      @(negedge clock);
    end
    drive('h400, 0, 0, 1, 0, 0);
    @(negedge clock);
    drive('h400, 0, 0, 0, 0, 0);
    #1;
    chk("wait mem_addr", bus.mem_addr, 'h400);
    chk("wait instr_pc", instr_pc, 'h100);
    #1 reset_n = 1'b0;
    #1 chk_regs("async reset", 0, 'h0, 0, B, 'h0, 0);
    @(negedge clock);
    reset_n = 1'b1;
    drive('h500, 0, 0, 0, 1, 32'h55555555);
    #1 chk("stale rsp pc_stall", 64'(pc_stall), 64'(1));
    @(negedge clock);
    drive('h500, 0, 0, 0, 0, 0);
    #1 chk_regs("after stale rsp", 1, 'h500, 0, B, 'h0, 0);
    @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    drive('h102, 0, 0, 0, 0, 0);
    #1;
`ifdef FETCH_MISALIGN_EN
    chk("misalign pc_stall", 64'(pc_stall), 64'(0));
    @(negedge clock);
    #1 chk_regs("misalign deliver", 0, 'h0, 1, B, 'h102, 1);
`else
    chk("misalign pc_stall", 64'(pc_stall), 64'(1));
    @(negedge clock);
    #1 chk_regs("misalign passthru", 1, 'h102, 0, B, 'h0, 0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
